// File: rtl/im_loader_if.sv
// Host byte stream, instruction-memory write port and loader status, bundled.
// The loader connects through the slave modport; the host side uses master.
interface im_loader_if #(
   parameter int ADDR_W = 16
) ();
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_waddr;
   logic [15:0]       im_wdata;
   logic              core_hold;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, im_we, im_waddr, im_wdata, core_hold, busy, done, err
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, im_we, im_waddr, im_wdata, core_hold, busy, done, err
   );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed, XOR-checksummed program from a host byte stream into
// instruction memory, holding the cores until a load completes successfully.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte; range-check the word count
// DATA_HI | expecting word high byte
// DATA_LO | expecting word low byte
// WRITE   | one-cycle instruction memory write, advance word counter
// CSUM    | expecting checksum byte
// DONE    | one-cycle success pulse, cores released
// ERR     | load failed; err held, cores held, wait for start
module im_loader #(
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_W    = 16
) (
   input logic        clk,
   input logic        rst,
   im_loader_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state, state_nx;
   logic [7:0]        len_hi, data_hi, csum;
   logic [15:0]       len, cnt, len_nx;
   logic              core_hold_q, im_we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [15:0]       wdata_q;
   logic              rdy, accept, start_ok;

   assign rdy      = state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
   assign accept   = bus.in_valid && rdy;
   assign start_ok = bus.start && (state inside {S_IDLE, S_DONE, S_ERR});
   assign len_nx   = {len_hi, bus.in_data};

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (start_ok) state_nx = S_LEN_HI;
         S_DONE:    state_nx = start_ok ? S_LEN_HI : S_IDLE;
         S_ERR:     if (start_ok) state_nx = S_LEN_HI;
         S_LEN_HI:  if (accept) state_nx = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_nx == 16'd0)
                  state_nx = S_CSUM;
               else if ({16'd0, len_nx} > MEM_DEPTH)
                  state_nx = S_ERR;
               else
                  state_nx = S_DATA_HI;
            end
         end
         S_DATA_HI: if (accept) state_nx = S_DATA_LO;
         S_DATA_LO: if (accept) state_nx = S_WRITE;
         S_WRITE:   state_nx = (cnt + 16'd1 == len) ? S_CSUM : S_DATA_HI;
         S_CSUM:    if (accept) state_nx = (bus.in_data == csum) ? S_DONE : S_ERR;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         len_hi      <= '0;
         len         <= '0;
         data_hi     <= '0;
         csum        <= '0;
         cnt         <= '0;
         core_hold_q <= 1'b1;
         im_we_q     <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state   <= state_nx;
         im_we_q <= (state_nx == S_WRITE);
         if (start_ok) begin
            cnt         <= '0;
            csum        <= '0;
            core_hold_q <= 1'b1;
         end
         // Cores are released only by a checksum-verified load.
         if (state_nx == S_DONE)
            core_hold_q <= 1'b0;
         if (accept) begin
            case (state)
               S_LEN_HI:  len_hi <= bus.in_data;
               S_LEN_LO:  len    <= len_nx;
               S_DATA_HI: begin
                  data_hi <= bus.in_data;
                  csum    <= csum ^ bus.in_data;
               end
               S_DATA_LO: begin
                  csum    <= csum ^ bus.in_data;
                  waddr_q <= ADDR_W'(cnt);
                  wdata_q <= {data_hi, bus.in_data};
               end
               default: ;
            endcase
         end
         if (state == S_WRITE)
            cnt <= cnt + 16'd1;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.im_we     = im_we_q;
   assign bus.im_waddr  = waddr_q;
   assign bus.im_wdata  = wdata_q;
   assign bus.core_hold = core_hold_q;
   assign bus.busy      = state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM};
   assign bus.done      = (state == S_DONE);
   assign bus.err       = (state == S_ERR);

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed and random program streams scored against a
// stream-level model of the expected writes and load outcome.
module tb_im_loader;
   localparam int MEM_DEPTH = 1024;
   localparam int ADDR_W    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   im_loader_if #(.ADDR_W(ADDR_W)) bus ();

   im_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  stream[$];
   logic [31:0] exp_writes[$];
   bit          exp_ok;
   int          exp_consumed;

   logic [31:0] wq[$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (bus.im_we === 1'b1) wq.push_back({bus.im_waddr, bus.im_wdata});
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stream-level reference: words land at consecutive addresses, checksum is
   // the XOR of the data bytes, oversize lengths fail after the length field.
   task automatic model();
      int         n;
      logic [7:0] cs, hi, lo;
      exp_writes.delete();
      n = int'({stream[0], stream[1]});
      if (n > MEM_DEPTH) begin
         exp_ok       = 1'b0;
         exp_consumed = 2;
         return;
      end
      cs = 8'h00;
      for (int k = 0; k < n; k++) begin
         hi = stream[2 + 2*k];
         lo = stream[3 + 2*k];
         cs = cs ^ hi ^ lo;
         exp_writes.push_back({16'(k), hi, lo});
      end
      exp_consumed = 3 + 2*n;
      exp_ok       = (stream[2 + 2*n] == cs);
   endtask

   task automatic build_rand(input int n, input bit good);
      logic [7:0] cs, b;
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      cs = 8'h00;
      for (int i = 0; i < 2*n; i++) begin
         b = 8'($urandom);
         cs = cs ^ b;
         stream.push_back(b);
      end
      stream.push_back(good ? cs : (cs ^ 8'h5A));
   endtask

   task automatic set_ref_stream(input logic [7:0] csum_byte);
      stream = '{8'h00, 8'h03, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h2D, csum_byte};
   endtask

   task automatic do_start(input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_start_err"},  32'(bus.err),  32'd0);
      check({tag, "_start_hold"}, 32'(bus.core_hold), 32'd1);
   endtask

   task automatic feed(input string tag, input int nbytes, input bit gaps, input bit mid_start);
      int idx    = 0;
      int budget = 0;
      bit did    = 1'b0;
      while (idx < nbytes && budget < 2000) begin
         @(negedge clk);
         budget++;
         bus.start = 1'b0;
         if (mid_start && !did && idx == 3) begin
            bus.start = 1'b1;
            did = 1'b1;
         end
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = stream[idx];
            if (bus.in_ready === 1'b1) idx++;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      check({tag, "_bytes_taken"}, 32'(idx), 32'(nbytes));
   endtask

   task automatic run(input string tag, input bit gaps, input bit mid_start);
      model();
      wq.delete();
      done_cnt = 0;
      do_start(tag);
      feed(tag, exp_consumed, gaps, mid_start);
      repeat (3) @(negedge clk);
      check({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_writes.size()));
      for (int i = 0; i < exp_writes.size(); i++)
         if (i < wq.size()) check($sformatf("%s_write%0d", tag, i), wq[i], exp_writes[i]);
      check({tag, "_done_pulses"}, 32'(done_cnt), exp_ok ? 32'd1 : 32'd0);
      check({tag, "_err"},       32'(bus.err),       exp_ok ? 32'd0 : 32'd1);
      check({tag, "_core_hold"}, 32'(bus.core_hold), exp_ok ? 32'd0 : 32'd1);
      check({tag, "_busy"},      32'(bus.busy),      32'd0);
      check({tag, "_we_idle"},   32'(bus.im_we),     32'd0);
      if (exp_writes.size() > 0)
         check({tag, "_wdata_hold"}, {bus.im_waddr, bus.im_wdata}, exp_writes[exp_writes.size()-1]);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 32'(bus.in_ready),  32'd0);
      check("rst_we",    32'(bus.im_we),     32'd0);
      check("rst_waddr", 32'(bus.im_waddr),  32'd0);
      check("rst_wdata", 32'(bus.im_wdata),  32'd0);
      check("rst_busy",  32'(bus.busy),      32'd0);
      check("rst_done",  32'(bus.done),      32'd0);
      check("rst_err",   32'(bus.err),       32'd0);
      check("rst_hold",  32'(bus.core_hold), 32'd1);

      set_ref_stream(8'h2B);
      run("good3", 1'b0, 1'b0);
      set_ref_stream(8'h00);
      run("badcsum", 1'b0, 1'b0);
      set_ref_stream(8'h2B);
      run("after_err", 1'b0, 1'b0);
      stream = '{8'h00, 8'h00, 8'h00};
      run("empty", 1'b0, 1'b0);
      stream = '{8'h04, 8'h01};
      run("oversize", 1'b0, 1'b0);
      stream = '{8'h04, 8'h00};
      model();
      check("maxlen_model_consumed", 32'(exp_consumed), 32'd2051);
      set_ref_stream(8'h2B);
      run("gaps_midstart", 1'b1, 1'b1);

      // Reset while the low byte of word 1 is pending.
      set_ref_stream(8'h2B);
      wq.delete();
      done_cnt = 0;
      do_start("midrst");
      feed("midrst", 5, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 32'(bus.in_ready),  32'd0);
      check("midrst_we",    32'(bus.im_we),     32'd0);
      check("midrst_waddr", 32'(bus.im_waddr),  32'd0);
      check("midrst_wdata", 32'(bus.im_wdata),  32'd0);
      check("midrst_busy",  32'(bus.busy),      32'd0);
      check("midrst_err",   32'(bus.err),       32'd0);
      check("midrst_hold",  32'(bus.core_hold), 32'd1);
      repeat (4) @(negedge clk);
      check("midrst_nwrites", 32'(wq.size()), 32'd1);
      if (wq.size() > 0) check("midrst_write0", wq[0], 32'h0000_0006);
      check("midrst_hold_late", 32'(bus.core_hold), 32'd1);
      check("midrst_done", 32'(done_cnt), 32'd0);

      for (int t = 0; t < 8; t++) begin
         build_rand($urandom_range(0, 6), 1'($urandom_range(0, 1)));
         run($sformatf("rand%0d", t), 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024: number of 16-bit instruction words the instruction memory can hold.
REQ-002 Parameter ADDR_W, default 16: width of the instruction memory write address.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a program load; honoured only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  host byte valid.
REQ-007 in_data  input  8  host byte.
REQ-008 in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid && in_ready.
REQ-009 im_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-010 im_waddr  output  ADDR_W  instruction memory word write address.
REQ-011 im_wdata  output  16  instruction word to write.
REQ-012 core_hold  output  1  holds all cores (NUM_C) stalled while program memory is invalid or loading.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  one-cycle pulse on successful load completion.
REQ-015 err  output  1  sticky load failure flag.

Function
REQ-016 The loader SHALL use states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE and ERR.
REQ-017 The host byte stream SHALL be: length N (16-bit word count, high byte first), then N words (high byte first), then one checksum byte.
REQ-018 From IDLE, DONE or ERR, start=1 SHALL go to LEN_HI, clear err, clear the word counter and checksum, and set busy=1 and core_hold=1 next cycle.
REQ-019 start SHALL be ignored in every other state.
REQ-020 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
REQ-021 The state SHALL advance only on an accepted byte; the loader SHALL hold indefinitely while in_valid=0.
REQ-022 On acceptance in LEN_LO:
  - N=0 -> CSUM;
  - N>MEM_DEPTH -> ERR;
  - otherwise -> DATA_HI.
REQ-023 The checksum SHALL be the XOR of all accepted data bytes only; length bytes are excluded.
REQ-024 DATA_HI SHALL latch the high byte; DATA_LO SHALL latch the low byte and go to WRITE.
REQ-025 In WRITE, for exactly one cycle, the loader SHALL drive im_we=1, im_waddr=word counter and im_wdata={hi,lo}, then increment the counter.
REQ-026 After WRITE, the loader SHALL go to CSUM if the counter equals N, else to DATA_HI.
REQ-027 Throughput SHALL be at most one word per 3 cycles.
REQ-028 Word k (0-based) SHALL be written to address k; no wrap-around is possible because N≤MEM_DEPTH.
REQ-029 In CSUM, an accepted byte equal to the running XOR SHALL go to DONE; a mismatch SHALL go to ERR.
REQ-030 DONE SHALL last one cycle:
  - done=1;
  - busy=0 and core_hold=0 from that cycle;
  - next state IDLE.
REQ-031 In ERR, the loader SHALL hold err=1, busy=0 and core_hold=1 until start or rst.
REQ-032 im_we, im_waddr and im_wdata SHALL be registered outputs.
REQ-033 im_waddr and im_wdata SHALL hold their last values when im_we=0.
REQ-034 im_we SHALL never assert outside WRITE.
REQ-035 Words already written before a failure SHALL remain written; core_hold stays 1 so they are never executed.

Reset
REQ-036 rst=1 SHALL force the following on the next edge:
  - state IDLE;
  - in_ready=0, im_we=0, im_waddr=0, im_wdata=0;
  - busy=0, done=0, err=0;
  - core_hold=1.
REQ-037 rst asserted mid-load SHALL abort with no further im_we pulse.
REQ-038 core_hold SHALL remain 1 after rst until a subsequent successful load reaches DONE.

Verification
REQ-039 Bytes 00 03 | 00 06 | 00 00 | 00 2D | 2B, valid every cycle: writes (0,0x0006), (1,0x0000), (2,0x002D); then done pulse; core_hold falls.
REQ-040 Same stream with checksum byte 0x00: ERR with err=1 and core_hold=1; the three writes still occur; a new start clears err.
REQ-041 Length 0x0401 with MEM_DEPTH=1024: ERR immediately after the second length byte; no im_we pulse.
REQ-042 Bytes 00 00 | 00: no writes, done pulse, core_hold=0.
REQ-043 rst asserted while in DATA_LO of word 1: no im_we for word 1; all outputs return to their reset values; core_hold=1.
REQ-044 in_valid toggling randomly, and start pulsed mid-load: identical write sequence to REQ-039; start has no effect.
